data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, log2 of the number of 32-bit words (256 words).
REQ-002 Parameter WAIT_CYCLES, default 2, wait states inserted before Ack; legal range 0..15.
REQ-003 Clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Clr  input  1  asynchronous, active-high reset.
REQ-005 Req  input  1  initiator request; sampled only in IDLE.
REQ-006 We  input  1  1 = write, 0 = read; sampled with Req.
REQ-007 Addr  input  32  byte address; sampled with Req.
REQ-008 WData  input  32  write data; sampled with Req.
REQ-009 BE  input  4  byte enables; BE[k] covers WData[8k+7:8k]; sampled with Req.
REQ-010 RData  output  32  read data.
REQ-011 Ack  output  1  one-cycle completion strobe.
REQ-012 Busy  output  1  high from the acceptance edge until the edge that ends the Ack cycle.
REQ-013 Err  output  1  misalignment error flag, qualified by Ack.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-015 IDLE with Req=1 at edge E0: latch We/Addr/WData/BE, set Busy; next state WAIT if WAIT_CYCLES>0, else RESP.
REQ-016 WAIT: the wait counter loads WAIT_CYCLES-1 at E0 and decrements each edge; the FSM moves to RESP at the edge where the counter is 0.
REQ-017 Ack SHALL be high for exactly one cycle, the cycle following edge E(WAIT_CYCLES+1); RESP returns to IDLE at the next edge.
REQ-018 Req SHALL be ignored in WAIT and RESP; minimum spacing between accepted requests is WAIT_CYCLES+2 cycles.
REQ-019 Word index = latched Addr[DEPTH_LOG2+1:2]; higher address bits are ignored, so addresses alias modulo 4*2^DEPTH_LOG2 bytes.
REQ-020 Write: at the edge entering RESP, update only the bytes with BE set; BE=4'b0000 writes nothing but still Acks.
REQ-021 Read: at the edge entering RESP, load RData with the full addressed word; BE is ignored.
REQ-022 RData SHALL hold its value until the next read completes; writes leave RData unchanged.
REQ-023 A write followed by a read of the same word SHALL return the written bytes merged with the unmodified bytes.

Reset
REQ-024 Clr=1 forces state IDLE, wait counter 0, Ack=0, Busy=0, Err=0, RData=0, regardless of Clk.
REQ-025 Reset mid-transaction abandons it: no memory write occurs and no Ack is issued.
REQ-026 Memory array contents are not reset.
REQ-027 The first request is sampled at the first rising edge after Clr deasserts.

Configuration
REQ-028 Macro DMEM_ALIGN_CHECK_EN defined: an access whose latched Addr[1:0]!=0 completes with normal timing, Ack=1 and Err=1, no memory write, and RData=0 for reads.
REQ-029 Macro DMEM_ALIGN_CHECK_EN undefined: Addr[1:0] is ignored, Err is tied 0, and no alignment logic is generated.

Verification (DEPTH_LOG2=8, WAIT_CYCLES=2 unless stated)
REQ-030 Reset-release check: Clr=1 for 100 ns, then 0 -> all outputs 0 and Busy=0 until the first Req.
REQ-031 Latency check: write Addr=0x10, WData=0xDEADBEEF, BE=4'hF at E0, then read 0x10 -> each Ack occurs exactly in the cycle after E3 and RData=0xDEADBEEF.
REQ-032 Byte-enable check: write 0x11223344 to 0x20 with BE=4'hF, then write 0xAABBCCDD with BE=4'b0101, then read 0x20 -> RData=0x11BB33DD.
REQ-033 Aliasing and Req-hold check: write 0x5 to Addr=0x400 (aliases word 0), then read Addr=0x0 -> RData=0x5; Req held high throughout -> a new request is accepted every 4 cycles.
REQ-034 Reset mid-transaction: write 0xFFFFFFFF to 0x30 with Clr pulsed during WAIT -> no Ack; a subsequent read of 0x30 returns its prior value.
REQ-035 With DMEM_ALIGN_CHECK_EN: write to Addr=0x42 -> Ack=1, Err=1, memory unchanged; with the macro undefined, the same access writes word 0x10 and Err=0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with byte enables and a fixed wait-state response.
// Optional misalignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module data_mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        Req,
  input  logic        We,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic [3:0]  BE,
  output logic [31:0] RData,
  output logic        Ack,
  output logic        Busy,
  output logic        Err,
  output logic [1:0]  o_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  // Handshake: Req/We/Addr/WData/BE are sampled only while IDLE; the access
  // completes with a single-cycle Ack exactly WAIT_CYCLES+1 edges after acceptance,
  // and Req is ignored until the FSM is back in IDLE during that Ack cycle.
  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic                  r_ack;
  logic                  r_busy;
  logic [31:0]           r_rdata;
  logic                  r_we;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [31:0]           r_wdata;
  logic [3:0]            r_be;
  logic [31:0]           r_mem [0:(2**DEPTH_LOG2)-1];

  logic                  w_accept;
  logic                  w_to_resp;
  logic                  w_cur_we;
  logic [DEPTH_LOG2-1:0] w_cur_idx;
  logic [31:0]           w_cur_wdata;
  logic [3:0]            w_cur_be;
  logic                  w_cur_mis;
  logic                  w_unused;

  assign w_accept  = (r_state == ST_IDLE) && Req;
  assign w_to_resp = ((r_state == ST_WAIT) && (r_cnt == 4'd0)) ||
                     (w_accept && (WAIT_CYCLES == 0));

  // With zero wait states RESP is entered on the acceptance edge, so the live inputs are used.
  assign w_cur_we    = (r_state == ST_IDLE) ? We                    : r_we;
  assign w_cur_idx   = (r_state == ST_IDLE) ? Addr[DEPTH_LOG2+1:2]  : r_idx;
  assign w_cur_wdata = (r_state == ST_IDLE) ? WData                 : r_wdata;
  assign w_cur_be    = (r_state == ST_IDLE) ? BE                    : r_be;

`ifdef DMEM_ALIGN_CHECK_EN
  logic r_mis;
  logic r_err;
  assign w_cur_mis = (r_state == ST_IDLE) ? (Addr[1:0] != 2'b00) : r_mis;
  assign w_unused  = ^Addr[31:DEPTH_LOG2+2];
  assign Err       = r_err;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_mis <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) r_mis <= (Addr[1:0] != 2'b00);
      r_err <= (r_state == ST_RESP) && r_mis;
    end
  end
`else
  assign w_cur_mis = 1'b0;
  assign w_unused  = ^{Addr[31:DEPTH_LOG2+2], Addr[1:0]};
  assign Err       = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= 32'd0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
    end else begin
      r_ack <= (r_state == ST_RESP);
      if (r_ack) r_busy <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Req) begin
            r_we    <= We;
            r_idx   <= Addr[DEPTH_LOG2+1:2];
            r_wdata <= WData;
            r_be    <= BE;
            r_busy  <= 1'b1;
            if (WAIT_CYCLES > 0) begin
              r_state <= ST_WAIT;
              r_cnt   <= CNT_INIT;
            end else begin
              r_state <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) r_state <= ST_RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      if (w_to_resp && !w_cur_we) begin
        r_rdata <= w_cur_mis ? 32'd0 : r_mem[w_cur_idx];
      end
    end
  end

  // Array is deliberately not reset; Clr gates the write so an abandoned access never lands.
  always_ff @(posedge Clk) begin
    if (!Clr && w_to_resp && w_cur_we && !w_cur_mis) begin
      for (int b = 0; b < 4; b++) begin
        if (w_cur_be[b]) r_mem[w_cur_idx][8*b +: 8] <= w_cur_wdata[8*b +: 8];
      end
    end
  end

  assign RData   = r_rdata;
  assign Ack     = r_ack;
  assign Busy    = r_busy;
  assign o_state = r_state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (DEPTH_LOG2=8, WAIT_CYCLES=2).
// Define DMEM_ALIGN_CHECK_EN for both files to exercise the misalignment path.
module tb_data_mem_responder;

  logic        clk;
  logic        clr;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;
  logic        err;
  logic [1:0]  state;

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;

  data_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut (
    .Clk(clk), .Clr(clr), .Req(req), .We(we), .Addr(addr), .WData(wdata),
    .BE(be), .RData(rdata), .Ack(ack), .Busy(busy), .Err(err), .o_state(state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete access; read expectations are popped from exp_q.
  task automatic do_xfer(input logic i_we, input logic [31:0] i_addr, input logic [31:0] i_wdata,
                         input logic [3:0] i_be, input logic exp_err);
    int lat;
    logic [31:0] exp_rd;
    @(negedge clk);
    req = 1'b1; we = i_we; addr = i_addr; wdata = i_wdata; be = i_be;
    @(posedge clk); #1;
    check("busy_at_e0", {31'd0, busy}, 32'd1);
    check("ack_at_e0", {31'd0, ack}, 32'd0);
    @(negedge clk);
    req = 1'b0;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = c;
        break;
      end
    end
    check("ack_latency", lat, 32'd3);
    check("err_at_ack", {31'd0, err}, {31'd0, exp_err});
    check("busy_at_ack", {31'd0, busy}, 32'd1);
    if (i_we) begin
      check("rdata_hold_on_write", rdata, last_rd);
    end else begin
      exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
      check("read_data", rdata, exp_rd);
      last_rd = exp_rd;
    end
    @(posedge clk); #1;
    check("ack_one_cycle", {31'd0, ack}, 32'd0);
    check("busy_after_ack", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat1;
    int lat2;
    n_checks = 0;
    n_fail   = 0;
    last_rd  = 32'd0;
    clr = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;

    // Reset release
    #50;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    #50;
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_ack", {31'd0, ack}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_err", {31'd0, err}, 32'd0);
      check("idle_rdata", rdata, 32'd0);
      check("idle_state", {30'd0, state}, 32'd0);
    end

    // Latency
    do_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    exp_q.push_back(32'hDEADBEEF);
    do_xfer(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);

    // Byte enables, including an all-zero mask
    do_xfer(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0);
    do_xfer(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0);
    exp_q.push_back(32'h11BB33DD);
    do_xfer(1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
    do_xfer(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0);
    exp_q.push_back(32'h11BB33DD);
    do_xfer(1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
    do_xfer(1'b1, 32'h24, 32'h55667788, 4'b1010, 1'b0);
    do_xfer(1'b1, 32'h24, 32'h00000000, 4'b0101, 1'b0);
    exp_q.push_back(32'h55007700);
    do_xfer(1'b0, 32'h24, 32'h0, 4'h0, 1'b0);

    // Aliasing with Req held high: write 0x400 then read 0x0 back-to-back
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h400; wdata = 32'h5; be = 4'hF;
    @(posedge clk); #1;
    check("hold_busy_e0", {31'd0, busy}, 32'd1);
    @(negedge clk);
    we = 1'b0; addr = 32'h0; wdata = 32'hFFFFFFFF;
    lat1 = 0;
    lat2 = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 4) check("hold_busy_e4", {31'd0, busy}, 32'd1);
      if (ack && lat1 == 0) lat1 = c;
      else if (ack && lat2 == 0) begin
        lat2 = c;
        break;
      end
      if (c == 4) begin
        @(negedge clk);
        req = 1'b0;
      end
    end
    check("hold_ack1_edge", lat1, 32'd3);
    check("hold_ack2_edge", lat2, 32'd7);
    check("alias_read", rdata, 32'h5);
    last_rd = 32'h5;
    @(posedge clk); #1;
    check("hold_busy_end", {31'd0, busy}, 32'd0);
    check("hold_state_end", {30'd0, state}, 32'd0);

    // Reset during WAIT abandons the write
    do_xfer(1'b1, 32'h30, 32'h01020304, 4'hF, 1'b0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'hFFFFFFFF; be = 4'hF;
    @(posedge clk); #1;
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #2;
    clr = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_state", {30'd0, state}, 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    last_rd = 32'd0;
    lat1 = 0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (ack) lat1 = c;
    end
    check("midrst_no_ack", lat1, 32'd0);
    exp_q.push_back(32'h01020304);
    do_xfer(1'b0, 32'h30, 32'h0, 4'h0, 1'b0);

    // Misaligned access
    do_xfer(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
    do_xfer(1'b1, 32'h42, 32'h12345678, 4'hF, 1'b1);
    exp_q.push_back(32'h0);
    do_xfer(1'b0, 32'h42, 32'h0, 4'h0, 1'b1);
    exp_q.push_back(32'hCAFEF00D);
    do_xfer(1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
`else
    do_xfer(1'b1, 32'h42, 32'h12345678, 4'hF, 1'b0);
    exp_q.push_back(32'h12345678);
    do_xfer(1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
`endif

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
